// File: rtl/ksa_wide_seq_if.sv
// Operand request / result handshake bundle for the wide KSA sequencer.
// The sequencer uses the slave side; the producer/consumer uses the master side.
interface ksa_wide_seq_if #(
    parameter int W = 16
) ();
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         op_cin;
    logic         busy;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport slave (
        input  start_valid, op_a, op_b, op_sub, op_cin, done_ready,
        output start_ready, busy, done_valid, result, cout, ovf
    );

    modport master (
        output start_valid, op_a, op_b, op_sub, op_cin, done_ready,
        input  start_ready, busy, done_valid, result, cout, ovf
    );
endinterface

// File: rtl/ksa_wide_seq.sv
// Multi-cycle W-bit add/subtract sequencer driving one shared SLICE_W-bit Kogge-Stone slice,
// LSB slice first, with the inter-slice carry held in a register.
module ksa_wide_seq #(
    parameter int SLICE_W = 4,
    parameter int NSLICES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ksa_wide_seq_if.slave      bus,
    output logic [SLICE_W-1:0] ksa_a,
    output logic [SLICE_W-1:0] ksa_b,
    output logic               ksa_cin,
    input  logic [SLICE_W-1:0] ksa_s,
    input  logic               ksa_cout
);
    localparam int W    = SLICE_W * NSLICES;
    localparam int IDXW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_beff;
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic            r_ovf;

    logic            w_ovf;

    // B is stored pre-inverted for subtraction so the slice always performs a plain add
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_beff   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_valid) begin
                        r_a     <= bus.op_a;
                        r_beff  <= bus.op_b ^ {W{bus.op_sub}};
                        r_carry <= bus.op_sub ? 1'b1 : bus.op_cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result[r_idx*SLICE_W +: SLICE_W] <= ksa_s;
                    r_carry <= ksa_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= ksa_cout;
                        r_ovf   <= w_ovf;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_ovf = (r_a[W-1] == r_beff[W-1]) && (ksa_s[SLICE_W-1] != r_a[W-1]);

    always_comb begin
        ksa_a   = '0;
        ksa_b   = '0;
        ksa_cin = 1'b0;
        if (r_state == RUN) begin
            ksa_a   = r_a[r_idx*SLICE_W +: SLICE_W];
            ksa_b   = r_beff[r_idx*SLICE_W +: SLICE_W];
            ksa_cin = r_carry;
        end
    end

    assign bus.start_ready = (r_state == IDLE);
    assign bus.busy        = (r_state == RUN);
    assign bus.done_valid  = (r_state == DONE);
    assign bus.result      = r_result;
    assign bus.cout        = r_cout;
    assign bus.ovf         = r_ovf;
endmodule
